// File: rtl/otp_session_arbiter_pkg.sv
// otp_session_arbiter_pkg: shared encodings and widths for the OTP session arbiter.
package otp_session_arbiter_pkg;

  localparam int DIGIT_W = 4;
  localparam int LOCK_W  = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GEN   = 2'd1,
    S_ENTRY = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/otp_lockout_timer.sv
// otp_lockout_timer: per-requester lockout down-counter; active while non-zero.
module otp_lockout_timer
  import otp_session_arbiter_pkg::*;
#(
  parameter logic [LOCK_W-1:0] LOAD_VAL = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic active
);

  logic [LOCK_W-1:0] cnt;

  // Load on a reset_sys session close, otherwise count down and saturate at zero.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - LOCK_W'(1);
    end
  end

  assign active = (cnt != '0);

endmodule

// File: rtl/otp_session_arbiter.sv
// otp_session_arbiter: round-robin owner of the shared OTP authentication FSM.
// Times the lfsr_latch pulse, forwards the owner's digits, closes the session on
// the FSM outcome flags and locks out a requester whose session ended in reset_sys.
// Build macro OTP_ARB_STATS_EN adds the ok_cnt/fail_cnt session tallies.
module otp_session_arbiter
  import otp_session_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int GEN_DELAY      = 16,
  parameter int LOCKOUT_CYCLES = 250_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [DIGIT_W*NUM_REQ-1:0] key_digit,
  input  logic [NUM_REQ-1:0]         key_valid,
  input  logic                       unlock,
  input  logic                       reset_sys,
  input  logic                       expired,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic                       lfsr_latch,
  output logic [DIGIT_W-1:0]         user_digit,
  output logic                       user_latch,
  output logic [NUM_REQ-1:0]         locked_out
`ifdef OTP_ARB_STATS_EN
  ,
  output logic [7:0]                 ok_cnt,
  output logic [7:0]                 fail_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int GEN_W = $clog2(GEN_DELAY);

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic [GEN_W-1:0]   gen_cnt;
  logic               seen_rst;
  logic               any_elig;
  logic               own_valid;
  logic [DIGIT_W-1:0] own_digit;
  logic               outcome;
  logic               session_close;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] lock_load;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'((v >= NUM_REQ) ? v - NUM_REQ : v);
  endfunction

  assign eligible      = req & ~locked_out;
  assign outcome       = unlock | reset_sys | expired;
  assign session_close = (state == S_HOLD) && !outcome;

  // Round-robin pick: first eligible requester at or after rr_ptr.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    any_elig = 1'b0;
    win_idx  = '0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = wrap_idx(int'(rr_ptr) + i);
      if (!any_elig && eligible[cand]) begin
        any_elig = 1'b1;
        win_idx  = cand;
      end
    end
  end

  // Owner's keypad lane, selected for forwarding.
  always_comb begin
    own_valid = 1'b0;
    own_digit = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (owner == IDX_W'(r)) begin
        own_valid = key_valid[r];
        own_digit = key_digit[r*DIGIT_W +: DIGIT_W];
      end
    end
  end

  // Session FSM with registered grant, busy, lfsr_latch and forwarded digit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      gen_cnt    <= '0;
      seen_rst   <= 1'b0;
      grant      <= '0;
      busy       <= 1'b0;
      lfsr_latch <= 1'b0;
      user_digit <= '0;
      user_latch <= 1'b0;
    end else begin
      lfsr_latch <= 1'b0;
      user_latch <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_elig) begin
            owner    <= win_idx;
            grant    <= NUM_REQ'(1) << win_idx;
            rr_ptr   <= wrap_idx(int'(win_idx) + 1);
            gen_cnt  <= GEN_W'(GEN_DELAY - 1);
            seen_rst <= 1'b0;
            busy     <= 1'b1;
            state    <= S_GEN;
          end
        end
        S_GEN: begin
          if (gen_cnt == '0) begin
            lfsr_latch <= 1'b1;
            state      <= S_ENTRY;
          end else begin
            gen_cnt <= gen_cnt - GEN_W'(1);
          end
        end
        S_ENTRY: begin
          if (own_valid) begin
            user_digit <= own_digit;
            user_latch <= 1'b1;
          end
          if (outcome) begin
            seen_rst <= reset_sys;
            state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          seen_rst <= seen_rst | reset_sys;
          if (!outcome) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_lock
    assign lock_load[r] = session_close && seen_rst && (owner == IDX_W'(r));

    otp_lockout_timer #(
      .LOAD_VAL(LOCK_W'(LOCKOUT_CYCLES))
    ) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (lock_load[r]),
      .tick  (1'b1),
      .active(locked_out[r])
    );
  end

`ifdef OTP_ARB_STATS_EN
  logic seen_ok;
  logic seen_fail;

  // Tally closed sessions by outcome, saturating at 255.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_ok   <= 1'b0;
      seen_fail <= 1'b0;
      ok_cnt    <= '0;
      fail_cnt  <= '0;
    end else begin
      if (state == S_IDLE) begin
        seen_ok   <= 1'b0;
        seen_fail <= 1'b0;
      end else if ((state == S_ENTRY) || (state == S_HOLD)) begin
        seen_ok   <= seen_ok | unlock;
        seen_fail <= seen_fail | reset_sys | expired;
      end
      if (session_close) begin
        if (seen_ok && (ok_cnt != 8'hFF)) begin
          ok_cnt <= ok_cnt + 8'd1;
        end
        if (seen_fail && (fail_cnt != 8'hFF)) begin
          fail_cnt <= fail_cnt + 8'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_otp_session_arbiter.sv
// tb_otp_session_arbiter: randomized scoreboard bench for otp_session_arbiter.
// Stimulus predicts each session's grant, lfsr_latch, digits and close from the
// arbitration rules and queues them; a negedge monitor pops and compares.
module tb_otp_session_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int GEN_DELAY = 4;
  localparam int LOCK_CYC  = 100;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] key_digit;
  logic [NUM_REQ-1:0]   key_valid;
  logic                 unlock, reset_sys, expired;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy, lfsr_latch, user_latch;
  logic [3:0]           user_digit;
  logic [NUM_REQ-1:0]   locked_out;
`ifdef OTP_ARB_STATS_EN
  logic [7:0]           ok_cnt, fail_cnt;
`endif

  otp_session_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .GEN_DELAY     (GEN_DELAY),
    .LOCKOUT_CYCLES(LOCK_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .key_digit (key_digit),
    .key_valid (key_valid),
    .unlock    (unlock),
    .reset_sys (reset_sys),
    .expired   (expired),
    .grant     (grant),
    .busy      (busy),
    .lfsr_latch(lfsr_latch),
    .user_digit(user_digit),
    .user_latch(user_latch),
    .locked_out(locked_out)
`ifdef OTP_ARB_STATS_EN
    ,
    .ok_cnt    (ok_cnt),
    .fail_cnt  (fail_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t grant_q[$];
  ev_t close_q[$];
  ev_t lfsr_q[$];
  ev_t dig_q[$];

  // Reference model: session-level view of the arbitration rules.
  int rr;
  int lock_start[NUM_REQ];
  int idle_from;
  int ok_m, fail_m;
  int fixed_digits[$];
  bit mon_en = 1'b0;

  function automatic bit model_locked(input int r, input int c);
    return (c >= lock_start[r]) && (c < lock_start[r] + LOCK_CYC);
  endfunction

  function automatic logic [NUM_REQ-1:0] stray_mask(input int owner);
    logic [NUM_REQ-1:0] m;
    m = NUM_REQ'($urandom);
    m[owner] = 1'b0;
    return m;
  endfunction

  // Monitor: compare every DUT event against the head of its queue.
  initial begin : monitor
    logic [NUM_REQ-1:0] prev;
    ev_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if ((prev == '0) && (grant != '0)) begin
          if (grant_q.size() == 0) check("grant_unexpected", int'(grant), 0);
          else begin
            e = grant_q.pop_front();
            check("grant_value", int'(grant), e.val);
            check("grant_cycle", cyc, e.cyc);
          end
        end else if ((prev != '0) && (grant == '0)) begin
          if (close_q.size() == 0) check("close_unexpected", int'(grant), int'(prev));
          else begin
            e = close_q.pop_front();
            check("close_cycle", cyc, e.cyc);
          end
        end else if (prev != grant) begin
          check("grant_stable", int'(grant), int'(prev));
        end
        if (lfsr_latch) begin
          if (lfsr_q.size() == 0) check("lfsr_unexpected", int'(lfsr_latch), 0);
          else begin
            e = lfsr_q.pop_front();
            check("lfsr_cycle", cyc, e.cyc);
          end
        end
        if (user_latch) begin
          if (dig_q.size() == 0) check("user_latch_unexpected", int'(user_latch), 0);
          else begin
            e = dig_q.pop_front();
            check("user_digit", int'(user_digit), e.val);
            check("user_latch_cycle", cyc, e.cyc);
          end
        end
        check("busy_vs_grant", int'(busy), int'(grant != '0));
        check("grant_onehot0", int'($onehot0(grant)), 1);
        for (int r = 0; r < NUM_REQ; r++)
          check($sformatf("locked_out[%0d]", r), int'(locked_out[r]), int'(model_locked(r, cyc)));
      end
      prev = grant;
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Assert reset between edges, check the reset state, release on a negedge.
  task automatic reset_dut(input bit mid_session);
    #2;
    if (mid_session) close_q.push_back('{cyc + 1, 0});
    reset = 1'b0;
    rr = 0;
    ok_m = 0;
    fail_m = 0;
    for (int r = 0; r < NUM_REQ; r++) lock_start[r] = -1_000_000;
    #1;
    check("rst_grant", int'(grant), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_lfsr_latch", int'(lfsr_latch), 0);
    check("rst_user_latch", int'(user_latch), 0);
    check("rst_user_digit", int'(user_digit), 0);
    check("rst_locked_out", int'(locked_out), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle_from = cyc;
  endtask

  // One session: outcome 0=unlock 1=reset_sys 2=expired; abort ends it by reset.
  task automatic run_session(input logic [NUM_REQ-1:0] req_v, input int ndig,
                             input int outcome, input bit drop_req, input bit abort);
    int  owner, c, glfsr, k, v;
    bit  found;
    owner = 0;
    found = 1'b0;
    while (cyc < idle_from) @(negedge clk);
    req = req_v;
    for (int t = 0; t < 400 && !found; t++) begin
      key_valid = NUM_REQ'($urandom);
      key_digit = 8'($urandom);
      for (int i = 0; i < NUM_REQ && !found; i++) begin
        int r;
        r = (rr + i) % NUM_REQ;
        if (req_v[r] && !model_locked(r, cyc)) begin
          found = 1'b1;
          owner = r;
        end
      end
      if (!found) @(negedge clk);
    end
    if (!found) begin
      errors++;
      $display("FAIL grant_wait: no eligible requester within 400 cycles");
      return;
    end
    c = cyc;
    grant_q.push_back('{c + 1, 1 << owner});
    rr = (owner + 1) % NUM_REQ;
    glfsr = c + 1 + GEN_DELAY;
    lfsr_q.push_back('{glfsr, 0});
    // Strobes in the grant cycle and during generation must be dropped.
    do begin
      @(negedge clk);
      if (cyc < glfsr) begin
        key_valid = NUM_REQ'($urandom);
        key_digit = 8'($urandom);
      end else begin
        key_valid = '0;
      end
      if (drop_req) req = '0;
    end while (cyc < glfsr);
    for (int d = 0; d < ndig; d++) begin
      repeat ($urandom_range(0, 2)) begin
        key_valid = stray_mask(owner);
        key_digit = 8'($urandom);
        @(negedge clk);
      end
      v = (fixed_digits.size() > 0) ? fixed_digits.pop_front() : int'($urandom_range(0, 15));
      key_digit = 8'($urandom);
      key_digit[owner*4 +: 4] = 4'(v);
      key_valid = stray_mask(owner) | (NUM_REQ'(1) << owner);
      dig_q.push_back('{cyc + 1, v});
      @(negedge clk);
    end
    key_valid = '0;
    if (abort) begin
      reset_dut(1'b1);
      req = '0;
      return;
    end
    case (outcome)
      0:       unlock    = 1'b1;
      1:       reset_sys = 1'b1;
      default: expired   = 1'b1;
    endcase
    k = $urandom_range(1, 3);
    repeat (k) @(negedge clk);
    unlock = 1'b0;
    reset_sys = 1'b0;
    expired = 1'b0;
    req = '0;
    close_q.push_back('{cyc + 1, 0});
    idle_from = cyc + 1;
    if (outcome == 1) lock_start[owner] = cyc + 1;
    if (outcome == 0) ok_m = (ok_m < 255) ? ok_m + 1 : 255;
    else fail_m = (fail_m < 255) ? fail_m + 1 : 255;
  endtask

  initial begin : stimulus
    reset = 1'b1;
    req = '0;
    key_digit = '0;
    key_valid = '0;
    unlock = 1'b0;
    reset_sys = 1'b0;
    expired = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk);
    reset_dut(1'b0);
    mon_en = 1'b1;

    // Single session with fixed digits; keypad 1 strobes are stray.
    fixed_digits = '{3, 7, 1, 9};
    run_session(2'b01, 4, 0, 1'b0, 1'b0);

    // Contention from reset: strict round-robin 01, 10, 01.
    @(negedge clk);
    reset_dut(1'b0);
    repeat (3) run_session(2'b11, 1, 0, 1'b0, 1'b0);

    // Lockout of keypad 0, keypad 1 served meanwhile, then keypad 0 after expiry.
    run_session(2'b01, 2, 1, 1'b0, 1'b0);
    run_session(2'b11, 1, 0, 1'b0, 1'b0);
    run_session(2'b01, 1, 0, 1'b0, 1'b0);

    // Expiry closes the session; dropped req does not end it early.
    run_session(2'b11, 1, 2, 1'b1, 1'b0);

    // Randomized sessions.
    for (int s = 0; s < 25; s++)
      run_session(NUM_REQ'($urandom_range(1, 3)), $urandom_range(0, 4),
                  ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(0, 2)) & 2,
                  1'($urandom), 1'b0);

    // Reset mid-entry aborts; the RR pointer restarts at keypad 0.
    run_session(2'b10, 2, 0, 1'b0, 1'b1);
    run_session(2'b11, 1, 0, 1'b0, 1'b0);

`ifdef OTP_ARB_STATS_EN
    while (cyc < idle_from) @(negedge clk);
    reset_dut(1'b0);
    run_session(2'b01, 1, 0, 1'b0, 1'b0);
    run_session(2'b10, 1, 0, 1'b0, 1'b0);
    run_session(2'b01, 1, 1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("ok_cnt_small", int'(ok_cnt), ok_m);
    check("fail_cnt_small", int'(fail_cnt), fail_m);
    for (int s = 0; s < 300; s++) run_session(2'b11, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("ok_cnt_sat", int'(ok_cnt), ok_m);
    check("fail_cnt_sat", int'(fail_cnt), fail_m);
`endif

    repeat (8) @(negedge clk);
    check("grant_q_drained", grant_q.size(), 0);
    check("close_q_drained", close_q.size(), 0);
    check("lfsr_q_drained", lfsr_q.size(), 0);
    check("dig_q_drained", dig_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
